// File: rtl/mem_arb_pkg.sv
// Shared constants, state/grant encodings and the round-robin pick for mem_access_arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_RD0  = 2'd2,
    GNT_RD1  = 2'd3
  } grant_t;

  // Cyclic order LD -> RD0 -> RD1, searching from the requester after `last`.
  function automatic grant_t rr_pick(grant_t last, logic ld, logic rd0, logic rd1);
    grant_t g;
    g = GNT_NONE;
    case (last)
      GNT_LD: begin
        if (rd0)      g = GNT_RD0;
        else if (rd1) g = GNT_RD1;
        else if (ld)  g = GNT_LD;
      end
      GNT_RD0: begin
        if (rd1)      g = GNT_RD1;
        else if (ld)  g = GNT_LD;
        else if (rd0) g = GNT_RD0;
      end
      default: begin
        if (ld)       g = GNT_LD;
        else if (rd0) g = GNT_RD0;
        else if (rd1) g = GNT_RD1;
      end
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_256x8.sv
// Single-port byte store: synchronous write, asynchronous (combinational) read.
module mem_256x8
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: storage arrays carry no reset so they map onto plain RAM cells;
  // initial contents come from the arbiter's clear sweep when it is built in.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin access controller (loader + two readers) for a single-port byte store.
// Define CLEAR_MEM_EN to build in the post-reset zero sweep of the whole store.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_restart,
  output logic [ADDR_W-1:0] ld_ptr,
  input  logic              rd0_valid,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_ready,
  output logic              rd0_rvalid,
  output logic [DATA_W-1:0] rd0_rdata,
  input  logic              rd1_valid,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_ready,
  output logic              rd1_rvalid,
  output logic [DATA_W-1:0] rd1_rdata,
  output logic              busy
);

  logic              run_en;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  grant_t            grant;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic              rd0_rvalid_q, rd0_rvalid_d;
  logic              rd1_rvalid_q, rd1_rvalid_d;
  logic [DATA_W-1:0] rd0_rdata_q, rd0_rdata_d;
  logic [DATA_W-1:0] rd1_rdata_q, rd1_rdata_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef CLEAR_MEM_EN
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign run_en   = (state_q == ST_RUN);
  assign clr_we   = ~run_en;
  assign clr_addr = clr_cnt_q;
  assign busy     = ~run_en;
`else
  assign run_en   = 1'b1;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  // Readys are gated by rst directly so they drop the moment reset rises.
  assign grant     = (run_en && !rst) ? rr_pick(last_grant_q, ld_valid, rd0_valid, rd1_valid)
                                      : GNT_NONE;
  assign ld_ready  = (grant == GNT_LD);
  assign rd0_ready = (grant == GNT_RD0);
  assign rd1_ready = (grant == GNT_RD1);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ld_ptr_q;
    mem_wdata = ld_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end
    case (grant)
      GNT_LD:  mem_we   = 1'b1;
      GNT_RD0: mem_addr = rd0_addr;
      GNT_RD1: mem_addr = rd1_addr;
      default: ;
    endcase
  end

  mem_256x8 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    ld_ptr_d = ld_ptr_q;
    if (grant == GNT_LD) ld_ptr_d = ld_ptr_q + 1'b1;
    // Restart wins over the increment; the granted write still uses the old pointer.
    if (ld_restart) ld_ptr_d = '0;

    last_grant_d = (grant == GNT_NONE) ? last_grant_q : grant;

    rd0_rvalid_d = (grant == GNT_RD0);
    rd1_rvalid_d = (grant == GNT_RD1);
    rd0_rdata_d  = rd0_rvalid_d ? mem_rdata : rd0_rdata_q;
    rd1_rdata_d  = rd1_rvalid_d ? mem_rdata : rd1_rdata_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_RD1;
      ld_ptr_q     <= '0;
      rd0_rvalid_q <= 1'b0;
      rd1_rvalid_q <= 1'b0;
      rd0_rdata_q  <= '0;
      rd1_rdata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      ld_ptr_q     <= ld_ptr_d;
      rd0_rvalid_q <= rd0_rvalid_d;
      rd1_rvalid_q <= rd1_rvalid_d;
      rd0_rdata_q  <= rd0_rdata_d;
      rd1_rdata_q  <= rd1_rdata_d;
    end
  end

  assign ld_ptr     = ld_ptr_q;
  assign rd0_rvalid = rd0_rvalid_q;
  assign rd1_rvalid = rd1_rvalid_q;
  assign rd0_rdata  = rd0_rdata_q;
  assign rd1_rdata  = rd1_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter; runs in either CLEAR_MEM_EN build.
module tb_mem_access_arbiter;

`ifdef CLEAR_MEM_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid, ld_ready, ld_restart;
  logic [7:0] ld_data, ld_ptr;
  logic       rd0_valid, rd0_ready, rd0_rvalid;
  logic [7:0] rd0_addr, rd0_rdata;
  logic       rd1_valid, rd1_ready, rd1_rvalid;
  logic [7:0] rd1_addr, rd1_rdata;
  logic       busy;

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_restart(ld_restart), .ld_ptr(ld_ptr),
    .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
    .rd0_rvalid(rd0_rvalid), .rd0_rdata(rd0_rdata),
    .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
    .rd1_rvalid(rd1_rvalid), .rd1_rdata(rd1_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: memory image, write pointer, last grant (0=LD,1=RD0,2=RD1).
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr;
  int         m_last;
  logic [7:0] m_rd0, m_rd1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [2:0] last_rdy;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns one-hot {ld,rd0,rd1} for the first requester after `last`.
  function automatic logic [2:0] exp_grant(logic [2:0] req, int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (req[2-idx]) return 3'b100 >> idx;
    end
    return 3'b000;
  endfunction

  // One run-state cycle: check outputs at negedge, advance the model, return at posedge+1.
  task automatic cycle();
    logic [2:0] g;
    @(negedge clk);
    check("rd0_rvalid", rd0_rvalid, q0.size() != 0);
    if (q0.size() != 0) m_rd0 = q0.pop_front();
    check("rd0_rdata", rd0_rdata, m_rd0);
    check("rd1_rvalid", rd1_rvalid, q1.size() != 0);
    if (q1.size() != 0) m_rd1 = q1.pop_front();
    check("rd1_rdata", rd1_rdata, m_rd1);
    check("busy", busy, 0);
    check("ld_ptr", ld_ptr, m_ptr);
    g = exp_grant({ld_valid, rd0_valid, rd1_valid}, m_last);
    last_rdy = {ld_ready, rd0_ready, rd1_ready};
    check("ready", last_rdy, g);
    if (g[2]) begin
      m_mem[m_ptr] = ld_data;
      m_ptr++;
      m_last = 0;
    end
    if (g[1]) begin
      q0.push_back(m_mem[rd0_addr]);
      m_last = 1;
    end
    if (g[0]) begin
      q1.push_back(m_mem[rd1_addr]);
      m_last = 2;
    end
    if (ld_restart) m_ptr = 8'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(int hold);
    rst = 1'b1;
    ld_valid = 1'b1; rd0_valid = 1'b1; rd1_valid = 1'b1; ld_restart = 1'b0;
    #1;
    check("rst_ready", {ld_ready, rd0_ready, rd1_ready}, 3'b000);
    check("rst_rvalid", {rd0_rvalid, rd1_rvalid}, 2'b00);
    check("rst_rdata0", rd0_rdata, 0);
    check("rst_rdata1", rd1_rdata, 0);
    check("rst_ld_ptr", ld_ptr, 0);
    check("rst_busy", busy, BUSY_RST);
    q0.delete(); q1.delete();
    m_ptr = 8'd0; m_last = 2; m_rd0 = 8'd0; m_rd1 = 8'd0;
    repeat (hold) @(posedge clk);
    #1;
    ld_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic clear_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("clr_busy", busy, 1);
      check("clr_ready", {ld_ready, rd0_ready, rd1_ready}, 3'b000);
      check("clr_rvalid", {rd0_rvalid, rd1_rvalid}, 2'b00);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0; ld_data = 8'h00; ld_restart = 1'b0;
    rd0_valid = 1'b0; rd0_addr = 8'h00;
    rd1_valid = 1'b0; rd1_addr = 8'h00;
    m_ptr = 8'd0; m_last = 2; m_rd0 = 8'd0; m_rd1 = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset(2);

`ifdef CLEAR_MEM_EN
    // Clear sweep with a reader already waiting; it is served in cycle 256.
    rd0_valid = 1'b1; rd0_addr = 8'h7F;
    clear_cycles(256);
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    cycle();
    check("clr_first_grant", last_rdy, 3'b010);
    rd0_valid = 1'b0;
    cycle();
    check("clr_rd_7f", rd0_rdata, 8'h00);
`else
    cycle();
    cycle();
`endif

    // Restart then stream four bytes; read one back on rd1.
    ld_restart = 1'b1;
    cycle();
    ld_restart = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 8'(8'h10 + i);
      cycle();
    end
    ld_valid = 1'b0;
    check("ld_ptr_4", ld_ptr, 8'd4);
    rd1_valid = 1'b1; rd1_addr = 8'd2;
    cycle();
    rd1_valid = 1'b0;
    cycle();
    check("rd1_addr2", rd1_rdata, 8'h12);

    // Full contention: grants rotate LD, RD0, RD1 with one ready per cycle.
    ld_valid = 1'b1; rd0_valid = 1'b1; rd1_valid = 1'b1;
    rd0_addr = 8'd0; rd1_addr = 8'd3;
    for (int i = 0; i < 9; i++) begin
      ld_data = 8'(8'h20 + i);
      cycle();
      check("rr_seq", last_rdy, 3'b100 >> (i % 3));
    end
    ld_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
    cycle();

    // 256 writes wrap the pointer; the 257th lands at address 0.
    ld_restart = 1'b1;
    cycle();
    ld_restart = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_data = 8'(i) ^ 8'h3C;
      cycle();
    end
    check("ld_ptr_wrap", ld_ptr, 8'd0);
    ld_data = 8'hAA;
    cycle();
    ld_valid = 1'b0;
    rd0_valid = 1'b1; rd0_addr = 8'd0;
    cycle();
    rd0_valid = 1'b0;
    cycle();
    check("wrap_rd0", rd0_rdata, 8'hAA);

    // Restart coincident with a granted write at pointer 9.
    ld_restart = 1'b1;
    cycle();
    ld_restart = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ld_data = 8'(8'h60 + i);
      cycle();
    end
    check("ld_ptr_9", ld_ptr, 8'd9);
    ld_data = 8'h55; ld_restart = 1'b1;
    cycle();
    ld_restart = 1'b0; ld_valid = 1'b0;
    check("restart_ptr0", ld_ptr, 8'd0);
    rd0_valid = 1'b1; rd0_addr = 8'd9;
    cycle();
    rd0_valid = 1'b0;
    cycle();
    check("restart_mem9", rd0_rdata, 8'h55);

    // Random traffic over a fully written store.
    for (int i = 0; i < 200; i++) begin
      ld_valid   = 1'($urandom_range(0, 1));
      rd0_valid  = 1'($urandom_range(0, 1));
      rd1_valid  = 1'($urandom_range(0, 1));
      ld_data    = 8'($urandom_range(0, 255));
      rd0_addr   = 8'($urandom_range(0, 255));
      rd1_addr   = 8'($urandom_range(0, 255));
      ld_restart = ($urandom_range(0, 7) == 0);
      cycle();
    end
    ld_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0; ld_restart = 1'b0;
    cycle();

    // Reset the cycle after an rd0 handshake: the pending pulse is dropped.
    rd0_valid = 1'b1; rd0_addr = 8'd9;
    cycle();
    rd0_valid = 1'b0;
    check("rd0_rvalid_pre", rd0_rvalid, 1);
    apply_reset(2);
`ifdef CLEAR_MEM_EN
    // Interrupt the sweep part-way; the full 256-cycle sweep must run again.
    clear_cycles(100);
    apply_reset(2);
    clear_cycles(256);
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
`endif
    cycle();
    cycle();
    rd0_valid = 1'b1; rd0_addr = 8'd9;
    cycle();
    rd0_valid = 1'b0;
    cycle();
    check("post_rst_mem9", rd0_rdata, m_mem[9]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
